// File: rtl/iddmm_loader_if.sv
// Operand stream in, operand-RAM write port out.
// The loader is the slave side of the stream and drives the write port.
interface iddmm_loader_if #(
    parameter int K      = 128,
    parameter int ADDR_W = 5
);
    logic              s_valid;
    logic              s_ready;
    logic [K-1:0]      s_data;
    logic              s_last;
    logic [2:0]        wr_ena;
    logic [ADDR_W-1:0] wr_addr;
    logic [K-1:0]      wr_x;
    logic [K-1:0]      wr_y;
    logic [K-1:0]      wr_m;
    logic [K-1:0]      wr_m1;

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1
    );

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1
    );
endinterface

// File: rtl/iddmm_loader.sv
// Streams x, y and (optionally) m into the multiplier operand RAMs, then
// issues one task_req and waits for task_end before reporting done.
module iddmm_loader #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                keep_m_i,
    input  logic [K-1:0]        m1_in_i,
    iddmm_loader_if.slave       bus,
    output logic                task_req_o,
    input  logic                task_end_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);
    typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_Y, LOAD_M, REQ, WAIT} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [K-1:0]      data_q, data_d;
    logic [K-1:0]      m1_q, m1_d;
    logic [2:0]        ena_q, ena_d;
    logic              keep_q, keep_d;
    logic              err_q, err_d;
    logic              treq_q, treq_d;
    logic              done_q, done_d;

    logic in_load, accept, last_word;

    assign in_load   = (state_q == LOAD_X) || (state_q == LOAD_Y) || (state_q == LOAD_M);
    assign accept    = in_load && bus.s_valid;
    assign last_word = (cnt_q == ADDR_W'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        m1_d    = m1_q;
        keep_d  = keep_q;
        err_d   = err_q;
        ena_d   = 3'b000;
        treq_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_X;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    keep_d  = keep_m_i;
                    if (!keep_m_i) m1_d = m1_in_i;
                end
            end
            LOAD_X, LOAD_Y, LOAD_M: begin
                if (accept) begin
                    ena_d  = (state_q == LOAD_X) ? 3'b001 :
                             (state_q == LOAD_Y) ? 3'b010 : 3'b100;
                    addr_d = cnt_q;
                    data_d = bus.s_data;
                    // s_last is only checked, never used to end an operand
                    if (bus.s_last != last_word) err_d = 1'b1;
                    if (last_word) begin
                        cnt_d   = '0;
                        state_d = (state_q == LOAD_X)            ? LOAD_Y :
                                  (state_q == LOAD_Y && !keep_q) ? LOAD_M : REQ;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            // REQ coincides with the last write strobe; task_req is its registered echo
            REQ: begin
                treq_d  = 1'b1;
                state_d = WAIT;
            end
            // done is shown while still in WAIT so a start on that cycle is dropped
            WAIT: begin
                if (done_q)          state_d = IDLE;
                else if (task_end_i) done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
            m1_q   <= '0;
            keep_q <= 1'b0;
            err_q  <= 1'b0;
            ena_q  <= 3'b000;
            treq_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            data_q <= data_d;
            m1_q   <= m1_d;
            keep_q <= keep_d;
            err_q  <= err_d;
            ena_q  <= ena_d;
            treq_q <= treq_d;
            done_q <= done_d;
        end
    end

    assign bus.s_ready = in_load;
    assign bus.wr_ena  = ena_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_x    = data_q;
    assign bus.wr_y    = data_q;
    assign bus.wr_m    = data_q;
    assign bus.wr_m1   = m1_q;
    assign task_req_o  = treq_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_iddmm_loader.sv
// Directed bench for iddmm_loader (K=16, N=4); write strobes are checked
// against a scoreboard filled as words are offered.
module tb_iddmm_loader;
    localparam int K = 16;
    localparam int N = 4;
    localparam int AW = 2;

    typedef struct packed {
        logic [2:0]    ena;
        logic [AW-1:0] addr;
        logic [K-1:0]  data;
    } wr_t;

    logic clk, rst, start, keep_m, task_req, task_end, busy, done, err;
    logic [K-1:0] m1_in;

    iddmm_loader_if #(.K(K), .ADDR_W(AW)) bus ();

    iddmm_loader #(.K(K), .N(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start_i(start), .keep_m_i(keep_m), .m1_in_i(m1_in),
        .bus(bus), .task_req_o(task_req), .task_end_i(task_end),
        .busy_o(busy), .done_o(done), .err_o(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    wr_t sb[$];
    int op, mcnt;
    bit mkeep;
    logic [K-1:0] m1_exp;
    int treq_cnt = 0, done_cnt = 0;
    bit prev_wr = 0, prev_treq = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (bus.wr_ena !== 3'b000) begin
            if (sb.size() == 0) chk("wr_unexpected", 32'(bus.wr_ena), 32'h0);
            else begin
                e = sb.pop_front();
                chk("wr_ena_addr_x", 32'({bus.wr_ena, bus.wr_addr, bus.wr_x}), 32'(e));
                chk("wr_y_m", {bus.wr_y, bus.wr_m}, {e.data, e.data});
            end
        end
        if (task_req === 1'b1) begin
            treq_cnt++;
            chk("treq_timing", 32'({prev_wr, prev_treq, sb.size() == 0}), 32'b101);
        end
        if (done === 1'b1) done_cnt++;
        prev_wr   = (bus.wr_ena !== 3'b000);
        prev_treq = (task_req === 1'b1);
    end

    task automatic do_start(input bit keep, input logic [K-1:0] m1);
        start = 1'b1; keep_m = keep; m1_in = m1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 0; mcnt = 0; mkeep = keep;
        if (!keep) m1_exp = m1;
        chk("busy_after_start", 32'(busy), 32'h1);
    endtask

    task automatic send(input logic [K-1:0] d, input logic l);
        int n = 0;
        wr_t e;
        e.ena = 3'(3'b001 << op); e.addr = AW'(mcnt); e.data = d;
        sb.push_back(e);
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = l;
        while (bus.s_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (bus.s_ready !== 1'b1) chk("ready_timeout", 32'(bus.s_ready), 32'h1);
        @(posedge clk); #1;
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
        if (mcnt == N - 1) begin
            mcnt = 0;
            op = (op == 0) ? 1 : (op == 1 && !mkeep) ? 2 : 3;
        end else mcnt++;
    endtask

    // Stream operands until the model says loading is over (or stop_after words)
    task automatic load(input bit gap, input int fop, input int fcnt,
                        input int stop_after, input bit tend_in_y);
        int n = 0;
        while (op != 3 && n != stop_after) begin
            logic l;
            l = (mcnt == N - 1);
            if (op == fop && mcnt == fcnt) l = !l;
            if (tend_in_y && op == 1 && mcnt == 1) task_end = 1'b1;
            send(16'($urandom), l);
            task_end = 1'b0;
            n++;
            if (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic finish(input bit start_in_wait, input bit start_on_done);
        int n = 0;
        do begin @(negedge clk); n++; end while (task_req !== 1'b1 && n < 20);
        chk("treq_seen", 32'(task_req), 32'h1);
        chk("sb_drained", 32'(sb.size()), 32'h0);
        chk("wr_m1", 32'(bus.wr_m1), 32'(m1_exp));
        if (start_in_wait) begin
            @(posedge clk); #1; start = 1'b1; keep_m = 1'b0; m1_in = 16'hBEEF;
            @(posedge clk); #1; start = 1'b0;
            @(negedge clk);
            chk("wait_start_ready", 32'(bus.s_ready), 32'h0);
            chk("wait_start_busy", 32'(busy), 32'h1);
        end
        @(posedge clk); #1; task_end = 1'b1;
        @(posedge clk); #1; task_end = 1'b0; start = start_on_done; keep_m = 1'b0;
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'h1);
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("done_cleared", 32'(done), 32'h0);
        chk("wr_m1_hold", 32'(bus.wr_m1), 32'(m1_exp));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_ready"}, 32'(bus.s_ready), 32'h0);
        chk({tag, "_wr"}, 32'({bus.wr_ena, bus.wr_addr}), 32'h0);
        chk({tag, "_data"}, {bus.wr_x, bus.wr_m1}, 32'h0);
        chk({tag, "_ctl"}, 32'({task_req, done, err}), 32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; keep_m = 1'b0; m1_in = '0; task_end = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
        m1_exp = '0; op = 3; mcnt = 0; mkeep = 0;
        #3 chk_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Full load back-to-back, modulus included
        do_start(1'b0, 16'hA5A5);
        chk("ready_in_load", 32'(bus.s_ready), 32'h1);
        load(1'b0, -1, 0, -1, 1'b0);
        finish(1'b0, 1'b0);

        // Reuse m: only x and y written, m1_in ignored
        do_start(1'b1, 16'h1234);
        load(1'b0, -1, 0, -1, 1'b0);
        finish(1'b0, 1'b0);

        // s_valid gaps between words
        do_start(1'b0, 16'h0F0F);
        load(1'b1, -1, 0, -1, 1'b0);
        finish(1'b0, 1'b0);

        // Early s_last on x word 1: err sticky, load still completes
        do_start(1'b0, 16'h5A5A);
        load(1'b0, 0, 1, -1, 1'b0);
        chk("err_early_last", 32'(err), 32'h1);
        finish(1'b0, 1'b0);
        chk("err_sticky", 32'(err), 32'h1);

        // Missing s_last on y word N-1
        do_start(1'b1, 16'h0000);
        chk("err_cleared", 32'(err), 32'h0);
        load(1'b0, 1, N - 1, -1, 1'b0);
        chk("err_missing_last", 32'(err), 32'h1);
        finish(1'b0, 1'b0);

        // Reset after 5 accepted words
        do_start(1'b0, 16'hC3C3);
        load(1'b0, -1, 0, 5, 1'b0);
        #1 rst = 1'b1;
        #1 chk_zero("midreset");
        sb.delete();
        m1_exp = '0;
        @(posedge clk); #1 rst = 1'b0;

        // First start after reset with keep_m=1 reuses m1 = 0
        do_start(1'b1, 16'h7777);
        load(1'b0, -1, 0, -1, 1'b0);
        finish(1'b0, 1'b0);

        // task_end during LOAD_Y, start during WAIT and on the done cycle
        do_start(1'b0, 16'h9696);
        load(1'b0, -1, 0, -1, 1'b1);
        finish(1'b1, 1'b1);

        repeat (3) @(negedge clk);
        chk("treq_total", 32'(treq_cnt), 32'd7);
        chk("done_total", 32'(done_cnt), 32'd7);
        chk("no_stray_wr", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
